key_range_dispatcher: RTL and testbench
=======================================

// Module: key_range_dispatcher
// PURPOSE
//  Upstream stage of the RC4 cracker core. Walks a programmable 24-bit key range and hands
//  one candidate key at a time to the core over a valid/ready handshake. It then waits for
//  the core's verdict: plaintext accepted, or rejected.
//  Stops on the first match, or when the range is exhausted. Holds the winning key and a tried-key count for LEDR/HEX.
// PARAMETERS
//  KEY_W        24      candidate key width (3 key bytes, MSB byte = key[0])
//  CNT_W        24      width of keys_tried counter
//  TIMEOUT_CYC  65536   max cycles in WAIT_RES before timeout_err (only with KEY_DISPATCH_TIMEOUT_EN)
// PORTS
//  CLOCK_50     in   1      system clock, all logic on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      1-cycle pulse: latch range, begin search
//  abort        in   1      level: return to IDLE next cycle
//  key_lo       in   KEY_W  first key of range (sampled on accepted start)
//  key_hi       in   KEY_W  last key of range, inclusive (sampled on accepted start)
//  cand_key     out  KEY_W  candidate key to core; stable while cand_valid
//  cand_valid   out  1      candidate offered
//  cand_ready   in   1      core accepts candidate
//  res_valid    in   1      1-cycle pulse: core verdict for last accepted candidate
//  res_match    in   1      verdict: 1 = all plaintext bytes in {a..z, space}
//  busy         out  1      ISSUE or WAIT_RES
//  found        out  1      sticky until next start/abort; found_key valid
//  found_key    out  KEY_W  matching key
//  exhausted    out  1      sticky: range ended without match
//  keys_tried   out  CNT_W  verdicts received since start, saturating
//  timeout_err  out  1      (KEY_DISPATCH_TIMEOUT_EN only) sticky: core never answered
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0: cand_key, cand_valid, busy, found, found_key, exhausted, keys_tried, timeout_err.
//  States: IDLE, ISSUE, WAIT_RES, FOUND, EXHAUSTED (registered, one-hot or binary).
//  start accepted in IDLE/FOUND/EXHAUSTED only; ignored while busy.
//   On accept: cur<=key_lo, hi<=key_hi, clear found/exhausted/keys_tried/timeout_err.
//   If key_lo>key_hi -> EXHAUSTED next cycle (zero keys tried); else -> ISSUE.
//  ISSUE: cand_valid=1, cand_key=cur. When cand_valid&&cand_ready -> WAIT_RES next cycle, cand_valid drops.
//  WAIT_RES: res_valid ignored outside this state. On res_valid, keys_tried+=1 (saturate at all-ones).
//   If res_match: found_key<=cur, found<=1 -> FOUND.
//   Else if cur==hi: exhausted<=1 -> EXHAUSTED.
//   Else cur<=cur+1 -> ISSUE.
//  Turnaround: from verdict to the next cand_valid is 1 cycle.
//  Range end: compare before increment, so key_hi=2^KEY_W-1 terminates with no wrap. cur never wraps.
//  abort: priority over all; any state -> IDLE. Clears cand_valid, busy and sticky flags; keys_tried is held.
//  If start and abort occur in the same cycle, abort wins.
//  FOUND/EXHAUSTED: hold outputs until start or abort.
//  Reset mid-search: immediate return to reset values. The core must also be reset.
// CONFIGURATION
//  `KEY_DISPATCH_TIMEOUT_EN defined: a wait counter is cleared on entering WAIT_RES and counts each cycle there.
//   When it reaches TIMEOUT_CYC with no res_valid: timeout_err<=1 and state -> EXHAUSTED (exhausted=1).
//  Undefined: no counter; timeout_err is tied 0; WAIT_RES waits indefinitely.
// STRUCTURE
//  rc4_crack_pkg: typedef enum dispatch_state_t; typedef logic [23:0] rc4_key_t;
//   localparams KEY_BYTES=3, MSG_LEN=32, ASCII_A=8'h61, ASCII_Z=8'h7A, ASCII_SP=8'h20.
//  One sub-module: dispatch_watchdog (counter + compare), instantiated only under the macro. FSM and datapath are inline.
// TESTING
//  1 Range 0x000000..0x000004; core rejects all -> 5 handshakes with cand_key 0..4, exhausted=1, keys_tried=5, found=0.
//  2 Range 0x000010..0x0000FF; match on 0x000013 -> found=1, found_key=0x000013, keys_tried=4, busy=0, cand_valid=0 after.
//  3 key_lo=0x000020, key_hi=0x00001F, start -> EXHAUSTED next cycle, keys_tried=0, no cand_valid.
//  4 Range 0xFFFFFE..0xFFFFFF, all rejected -> cand_key FFFFFE then FFFFFF, exhausted=1, no wrap to 0.
//  5 cand_ready held low 10 cycles -> cand_valid/cand_key stable; stray res_valid in ISSUE ignored (keys_tried unchanged).
//  6 abort asserted mid-WAIT_RES -> IDLE next cycle, busy=0, found=exhausted=0. With macro, TIMEOUT_CYC=16 and no res_valid -> timeout_err=1 after 16 cycles.

Source files
------------

// File: rtl/rc4_crack_pkg.sv
// Shared types and constants for the RC4 cracker datapath.
package rc4_crack_pkg;

  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned MSG_LEN   = 32;
  localparam logic [7:0]  ASCII_A   = 8'h61;
  localparam logic [7:0]  ASCII_Z   = 8'h7A;
  localparam logic [7:0]  ASCII_SP  = 8'h20;

  typedef logic [23:0] rc4_key_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_FOUND,
    ST_EXHAUSTED
  } dispatch_state_t;

  // Plaintext byte acceptance test used by the core's verdict logic.
  function automatic logic is_plain_char(input logic [7:0] c);
    return ((c >= ASCII_A) && (c <= ASCII_Z)) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Cycle counter that flags a core which never returns a verdict.
module dispatch_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_c = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (en && !expired_c)  cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_range_dispatcher.sv
// Walks a key range, offering one candidate at a time to the RC4 core and collecting verdicts.
// Optional core-response watchdog enabled by defining KEY_DISPATCH_TIMEOUT_EN.
module key_range_dispatcher
  import rc4_crack_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_BYTES * 8,
  parameter int unsigned CNT_W = 24
`ifdef KEY_DISPATCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65536
`endif
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  output logic [KEY_W-1:0] cand_key,
  output logic             cand_valid,
  input  logic             cand_ready,
  input  logic             res_valid,
  input  logic             res_match,
  output logic             busy,
  output logic             found,
  output logic [KEY_W-1:0] found_key,
  output logic             exhausted,
  output logic [CNT_W-1:0] keys_tried,
  output logic             timeout_err
);

  dispatch_state_t state_q, state_d;

  logic [KEY_W-1:0] cur_q, cur_d, hi_q, hi_d, found_key_q, found_key_d;
  logic [CNT_W-1:0] keys_q, keys_d;
  logic cand_valid_q, cand_valid_d, busy_q, busy_d;
  logic found_q, found_d, exh_q, exh_d, tmo_q, tmo_d;

  logic idle_like_c, start_acc_c, hs_c, verdict_c, timeout_c;

  assign idle_like_c = (state_q == ST_IDLE) || (state_q == ST_FOUND) || (state_q == ST_EXHAUSTED);
  assign start_acc_c = start && !abort && idle_like_c;
  assign hs_c        = (state_q == ST_ISSUE) && cand_valid_q && cand_ready;
  assign verdict_c   = (state_q == ST_WAIT_RES) && res_valid;

`ifdef KEY_DISPATCH_TIMEOUT_EN
  dispatch_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .clr       (hs_c),
    .en        (state_q == ST_WAIT_RES),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Range end is tested before incrementing so cur never wraps past all-ones.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED:
          if (start) state_d = (key_lo > key_hi) ? ST_EXHAUSTED : ST_ISSUE;
        ST_ISSUE:
          if (hs_c) state_d = ST_WAIT_RES;
        ST_WAIT_RES:
          if (verdict_c) begin
            if (res_match)          state_d = ST_FOUND;
            else if (cur_q == hi_q) state_d = ST_EXHAUSTED;
            else                    state_d = ST_ISSUE;
          end else if (timeout_c) begin
            state_d = ST_EXHAUSTED;
          end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_d        = cur_q;
    hi_d         = hi_q;
    found_key_d  = found_key_q;
    keys_d       = keys_q;
    found_d      = found_q;
    exh_d        = exh_q;
    tmo_d        = tmo_q;
    cand_valid_d = (state_d == ST_ISSUE);
    busy_d       = (state_d == ST_ISSUE) || (state_d == ST_WAIT_RES);
    if (abort) begin
      found_d = 1'b0;
      exh_d   = 1'b0;
      tmo_d   = 1'b0;
    end else if (start_acc_c) begin
      cur_d   = key_lo;
      hi_d    = key_hi;
      found_d = 1'b0;
      exh_d   = (key_lo > key_hi);
      keys_d  = '0;
      tmo_d   = 1'b0;
    end else if (verdict_c) begin
      keys_d = (keys_q == '1) ? keys_q : keys_q + CNT_W'(1);
      if (res_match) begin
        found_key_d = cur_q;
        found_d     = 1'b1;
      end else if (cur_q == hi_q) begin
        exh_d = 1'b1;
      end else begin
        cur_d = cur_q + KEY_W'(1);
      end
    end else if (timeout_c) begin
      tmo_d = 1'b1;
      exh_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_q        <= '0;
      hi_q         <= '0;
      found_key_q  <= '0;
      keys_q       <= '0;
      cand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      hi_q         <= hi_d;
      found_key_q  <= found_key_d;
      keys_q       <= keys_d;
      cand_valid_q <= cand_valid_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exh_q        <= exh_d;
      tmo_q        <= tmo_d;
    end
  end

  assign cand_key    = cur_q;
  assign cand_valid  = cand_valid_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_key   = found_key_q;
  assign exhausted   = exh_q;
  assign keys_tried  = keys_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_key_range_dispatcher.sv
// Directed bench for key_range_dispatcher with a hand-driven core model.
module tb_key_range_dispatcher;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [23:0] key_lo, key_hi;
  logic [23:0] cand_key;
  logic        cand_valid, cand_ready;
  logic        res_valid, res_match;
  logic        busy, found, exhausted, timeout_err;
  logic [23:0] found_key, keys_tried;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

`ifdef KEY_DISPATCH_TIMEOUT_EN
  key_range_dispatcher #(.TIMEOUT_CYC(16)) dut (
`else
  key_range_dispatcher dut (
`endif
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .key_lo      (key_lo),
    .key_hi      (key_hi),
    .cand_key    (cand_key),
    .cand_valid  (cand_valid),
    .cand_ready  (cand_ready),
    .res_valid   (res_valid),
    .res_match   (res_match),
    .busy        (busy),
    .found       (found),
    .found_key   (found_key),
    .exhausted   (exhausted),
    .keys_tried  (keys_tried),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [23:0] lo, input logic [23:0] hi);
    key_lo = lo;
    key_hi = hi;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Accept one candidate (bounded wait), then return a verdict after 'dly' cycles.
  task automatic serve(input logic [23:0] exp_key, input logic match, input int dly);
    int n = 0;
    while (!cand_valid && n < 20) begin
      tick();
      n++;
    end
    chk1("cand_valid_wait", cand_valid, 1'b1);
    chk24("cand_key", cand_key, exp_key);
    cand_ready = 1'b1;
    tick();
    cand_ready = 1'b0;
    chk1("cv_drop_after_hs", cand_valid, 1'b0);
    repeat (dly) tick();
    res_valid = 1'b1;
    res_match = match;
    tick();
    res_valid = 1'b0;
    res_match = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    key_lo = '0; key_hi = '0;
    cand_ready = 1'b0; res_valid = 1'b0; res_match = 1'b0;
    tick(); tick();

    // Reset values
    chk1("rst_cand_valid", cand_valid, 1'b0);
    chk24("rst_cand_key", cand_key, 24'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_found", found, 1'b0);
    chk24("rst_found_key", found_key, 24'h0);
    chk1("rst_exhausted", exhausted, 1'b0);
    chk24("rst_keys_tried", keys_tried, 24'h0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: range 0..4, all rejected
    do_start(24'h000000, 24'h000004);
    chk1("t1_busy", busy, 1'b1);
    serve(24'h000000, 1'b0, 1);
    chk1("t1_turnaround", cand_valid, 1'b1);
    serve(24'h000001, 1'b0, 0);
    serve(24'h000002, 1'b0, 2);
    serve(24'h000003, 1'b0, 0);
    serve(24'h000004, 1'b0, 1);
    chk1("t1_exhausted", exhausted, 1'b1);
    chk24("t1_keys_tried", keys_tried, 24'd5);
    chk1("t1_found", found, 1'b0);
    chk1("t1_busy_end", busy, 1'b0);
    chk1("t1_cv_end", cand_valid, 1'b0);

    // 2: match on 0x13
    do_start(24'h000010, 24'h0000FF);
    chk1("t2_exh_cleared", exhausted, 1'b0);
    serve(24'h000010, 1'b0, 0);
    serve(24'h000011, 1'b0, 0);
    serve(24'h000012, 1'b0, 0);
    serve(24'h000013, 1'b1, 1);
    chk1("t2_found", found, 1'b1);
    chk24("t2_found_key", found_key, 24'h000013);
    chk24("t2_keys_tried", keys_tried, 24'd4);
    chk1("t2_busy", busy, 1'b0);
    chk1("t2_cand_valid", cand_valid, 1'b0);
    repeat (3) tick();
    chk1("t2_found_hold", found, 1'b1);

    // 3: empty range from FOUND
    do_start(24'h000020, 24'h00001F);
    chk1("t3_exhausted", exhausted, 1'b1);
    chk24("t3_keys_tried", keys_tried, 24'd0);
    chk1("t3_cand_valid", cand_valid, 1'b0);
    chk1("t3_found_cleared", found, 1'b0);
    chk1("t3_busy", busy, 1'b0);

    // 4: top of key space, no wrap
    do_start(24'hFFFFFE, 24'hFFFFFF);
    serve(24'hFFFFFE, 1'b0, 0);
    serve(24'hFFFFFF, 1'b0, 0);
    tick(); tick();
    chk1("t4_exhausted", exhausted, 1'b1);
    chk24("t4_keys_tried", keys_tried, 24'd2);
    chk1("t4_cand_valid", cand_valid, 1'b0);
    chk24("t4_no_wrap", cand_key, 24'hFFFFFF);

    // 5: backpressure and stray verdict in ISSUE
    do_start(24'h000100, 24'h000105);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4 || i == 9) begin
        chk1("t5_cv_stable", cand_valid, 1'b1);
        chk24("t5_key_stable", cand_key, 24'h000100);
      end
    end
    res_valid = 1'b1; res_match = 1'b1;
    tick();
    res_valid = 1'b0; res_match = 1'b0;
    chk24("t5_stray_keys", keys_tried, 24'd0);
    chk1("t5_stray_found", found, 1'b0);
    chk1("t5_still_issue", cand_valid, 1'b1);
    serve(24'h000100, 1'b0, 0);

    // 6: abort mid-WAIT_RES
    chk24("t6_key", cand_key, 24'h000101);
    cand_ready = 1'b1;
    tick();
    cand_ready = 1'b0;
    chk1("t6_busy_wait", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_cand_valid", cand_valid, 1'b0);
    chk1("t6_found", found, 1'b0);
    chk1("t6_exhausted", exhausted, 1'b0);
    chk24("t6_keys_held", keys_tried, 24'd1);

    // start and abort together: abort wins
    key_lo = 24'h000000; key_hi = 24'h000003;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk1("t6_abort_wins_busy", busy, 1'b0);
    chk1("t6_abort_wins_cv", cand_valid, 1'b0);
    chk1("t6_timeout_err_low", timeout_err, 1'b0);

`ifdef KEY_DISPATCH_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYC=16
    do_start(24'h000000, 24'h000005);
    cand_ready = 1'b1;
    tick();
    cand_ready = 1'b0;
    repeat (15) tick();
    chk1("tmo_not_yet", timeout_err, 1'b0);
    chk1("tmo_busy_yet", busy, 1'b1);
    tick();
    chk1("tmo_err", timeout_err, 1'b1);
    chk1("tmo_exhausted", exhausted, 1'b1);
    chk1("tmo_busy", busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
